// File: rtl/float_to_int.sv
// IEEE-754 binary32 to signed int32 converter, three register stages with a global stall.
// Define FLOAT_TO_INT_RNE_EN for round-to-nearest-even; otherwise truncates toward zero.
module float_to_int (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    output logic [31:0] m_axis_result_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready
);

    logic        advance_s;
    logic        accept_s;
    logic        zero_in_s;
    logic        nan_in_s;
    logic        inf_in_s;

    logic        v1_r;
    logic        sign1_r;
    logic [7:0]  exp1_r;
    logic [23:0] sig1_r;
    logic        zero1_r;
    logic        nan1_r;
    logic        inf1_r;

    logic [31:0] mag_s;
    logic        sat_s;
    logic        sat_neg_s;

    logic        v2_r;
    logic        sign2_r;
    logic [31:0] mag2_r;
    logic        sat2_r;
    logic        sat_neg2_r;

    logic [31:0] mag_rnd_s;
    logic [31:0] result_s;

    logic        out_valid_r;
    logic [31:0] out_data_r;

`ifdef FLOAT_TO_INT_RNE_EN
    logic [55:0] wide_s;
    logic        guard_s;
    logic        sticky_s;
    logic        guard2_r;
    logic        sticky2_r;
`endif

    assign advance_s            = !out_valid_r | m_axis_result_tready;
    assign s_axis_a_tready      = advance_s & !areset;
    assign accept_s             = s_axis_a_tvalid & s_axis_a_tready;
    assign m_axis_result_tvalid = out_valid_r;
    assign m_axis_result_tdata  = out_data_r;

    assign zero_in_s = (s_axis_a_tdata[30:23] == 8'd0);
    assign nan_in_s  = (s_axis_a_tdata[30:23] == 8'd255) && (s_axis_a_tdata[22:0] != 23'd0);
    assign inf_in_s  = (s_axis_a_tdata[30:23] == 8'd255) && (s_axis_a_tdata[22:0] == 23'd0);

`ifdef FLOAT_TO_INT_RNE_EN
    // Fixed-point alignment: bits [55:24] integer part, [23] guard, [22:0] sticky (shift = e+1)
    assign wide_s = {32'd0, sig1_r} << (exp1_r - 8'd126);
`endif

    // Stage 2 combinational: align the significand and classify the saturating cases
    always_comb begin
        mag_s     = 32'd0;
`ifdef FLOAT_TO_INT_RNE_EN
        guard_s   = 1'b0;
        sticky_s  = 1'b0;
`endif
        sat_s     = nan1_r | inf1_r | (exp1_r >= 8'd158);
        sat_neg_s = nan1_r | sign1_r;
`ifdef FLOAT_TO_INT_RNE_EN
        if (!zero1_r && (exp1_r >= 8'd126) && (exp1_r <= 8'd157)) begin
            mag_s    = wide_s[55:24];
            guard_s  = wide_s[23];
            sticky_s = |wide_s[22:0];
        end else begin
            mag_s    = 32'd0;
        end
`else
        if (!zero1_r && (exp1_r >= 8'd150) && (exp1_r <= 8'd157)) begin
            mag_s = {8'd0, sig1_r} << (exp1_r - 8'd150);
        end else if (!zero1_r && (exp1_r >= 8'd127) && (exp1_r < 8'd150)) begin
            mag_s = {8'd0, sig1_r} >> (8'd150 - exp1_r);
        end else begin
            mag_s = 32'd0;
        end
`endif
    end

    // Stage 3 combinational: round (optional), negate and saturate
    always_comb begin
`ifdef FLOAT_TO_INT_RNE_EN
        mag_rnd_s = mag2_r + {31'd0, guard2_r & (sticky2_r | mag2_r[0])};
`else
        mag_rnd_s = mag2_r;
`endif
        if (sat2_r) begin
            result_s = sat_neg2_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (sign2_r) begin
            result_s = 32'd0 - mag_rnd_s;
        end else begin
            result_s = mag_rnd_s;
        end
    end

    // Pipeline registers: every stage moves together when the output can advance
    always_ff @(posedge aclk) begin
        if (areset) begin
            v1_r        <= 1'b0;
            sign1_r     <= 1'b0;
            exp1_r      <= 8'd0;
            sig1_r      <= 24'd0;
            zero1_r     <= 1'b0;
            nan1_r      <= 1'b0;
            inf1_r      <= 1'b0;
            v2_r        <= 1'b0;
            sign2_r     <= 1'b0;
            mag2_r      <= 32'd0;
            sat2_r      <= 1'b0;
            sat_neg2_r  <= 1'b0;
`ifdef FLOAT_TO_INT_RNE_EN
            guard2_r    <= 1'b0;
            sticky2_r   <= 1'b0;
`endif
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
        end else if (advance_s) begin
            v1_r        <= accept_s;
            sign1_r     <= s_axis_a_tdata[31];
            exp1_r      <= s_axis_a_tdata[30:23];
            sig1_r      <= {!zero_in_s, s_axis_a_tdata[22:0]};
            zero1_r     <= zero_in_s;
            nan1_r      <= nan_in_s;
            inf1_r      <= inf_in_s;
            v2_r        <= v1_r;
            sign2_r     <= sign1_r;
            mag2_r      <= mag_s;
            sat2_r      <= sat_s;
            sat_neg2_r  <= sat_neg_s;
`ifdef FLOAT_TO_INT_RNE_EN
            guard2_r    <= guard_s;
            sticky2_r   <= sticky_s;
`endif
            out_valid_r <= v2_r;
            out_data_r  <= result_s;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// Directed self-checking bench for float_to_int; expectations follow FLOAT_TO_INT_RNE_EN.
module tb_float_to_int;

    logic        aclk;
    logic        areset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;

    logic [31:0] vin [0:15];
    logic [31:0] got [0:15];
    int got_n;
    int stall_seen;
    int stall_bad;
    int lat;
    int timed_out;
    int checks;
    int errors;

    float_to_int dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_a_tdata       (s_tdata),
        .s_axis_a_tvalid      (s_tvalid),
        .s_axis_a_tready      (s_tready),
        .m_axis_result_tdata  (m_tdata),
        .m_axis_result_tvalid (m_tvalid),
        .m_axis_result_tready (m_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Streams vin[0..n-1], records results, optional consumer stall window; handshakes sampled mid-cycle
    task automatic run_stream(input int n, input int stall_at, input int stall_len);
        int idx;
        int cyc;
        int acc_cyc;
        logic [31:0] prev;
        logic prev_stall;
        for (int i = 0; i < 16; i++) got[i] = 32'hDEAD_BEEF;
        got_n = 0; idx = 0; cyc = 0; acc_cyc = -1; lat = -1;
        stall_seen = 0; stall_bad = 0; prev = 32'd0; prev_stall = 1'b0;
        @(posedge aclk); #1;
        s_tvalid = 1'b1; s_tdata = vin[0]; m_tready = 1'b1;
        while (got_n < n && cyc < 200) begin
            @(negedge aclk);
            if (m_tvalid && !m_tready) begin
                stall_seen++;
                if (s_tready !== 1'b0) stall_bad++;
                if (prev_stall && m_tdata !== prev) stall_bad++;
                prev = m_tdata;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (m_tvalid && m_tready) begin
                if (lat < 0) lat = cyc - acc_cyc;
                got[got_n] = m_tdata;
                got_n++;
            end
            if (s_tvalid && s_tready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                idx++;
            end
            cyc++;
            @(posedge aclk); #1;
            s_tvalid = (idx < n);
            s_tdata  = (idx < n) ? vin[idx] : 32'd0;
            m_tready = !(cyc >= stall_at && cyc < stall_at + stall_len);
        end
        timed_out = (got_n < n) ? 1 : 0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
    endtask

    task automatic test_reset();
        areset = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h3F80_0000; m_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b expected 0", m_tvalid); end
        checks++; if (m_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata got %08h expected 00000000", m_tdata); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %0b expected 0", s_tready); end
        areset = 1'b0; s_tvalid = 1'b0;
        @(posedge aclk); #1;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %0b expected 1", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_tvalid got %0b expected 0", m_tvalid); end
    endtask

    task automatic test_basic();
        logic [31:0] ex [0:2];
        ex[0] = 32'd1; ex[1] = 32'hFFFF_FFFE;
`ifdef FLOAT_TO_INT_RNE_EN
        ex[2] = 32'd4;
`else
        ex[2] = 32'd3;
`endif
        vin[0] = 32'h3F80_0000; vin[1] = 32'hC020_0000; vin[2] = 32'h4060_0000;
        run_stream(3, 1000, 0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout got %0d results expected 3", got_n); end
        checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency got %0d expected 3", lat); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== ex[i]) begin errors++; $display("FAIL basic[%0d] got %08h expected %08h", i, got[i], ex[i]); end
        end
    endtask

    task automatic test_specials();
        logic [31:0] ex [0:5];
        vin[0] = 32'h0000_0000; vin[1] = 32'h8000_0000; vin[2] = 32'h0000_0001;
        vin[3] = 32'h7F80_0000; vin[4] = 32'hFF80_0000; vin[5] = 32'h7FC0_0000;
        ex[0] = 32'd0; ex[1] = 32'd0; ex[2] = 32'd0;
        ex[3] = 32'h7FFF_FFFF; ex[4] = 32'h8000_0000; ex[5] = 32'h8000_0000;
        run_stream(6, 1000, 0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL specials_timeout got %0d results expected 6", got_n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== ex[i]) begin errors++; $display("FAIL specials[%0d] got %08h expected %08h", i, got[i], ex[i]); end
        end
    endtask

    task automatic test_range();
        logic [31:0] ex [0:3];
        vin[0] = 32'h4EFF_FFFF; vin[1] = 32'h4F00_0000; vin[2] = 32'hCF00_0000; vin[3] = 32'hCF00_0001;
        ex[0] = 32'h7FFF_FF80; ex[1] = 32'h7FFF_FFFF; ex[2] = 32'h8000_0000; ex[3] = 32'h8000_0000;
        run_stream(4, 1000, 0);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL range_timeout got %0d results expected 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== ex[i]) begin errors++; $display("FAIL range[%0d] got %08h expected %08h", i, got[i], ex[i]); end
        end
    endtask

    task automatic test_backpressure();
        vin[0] = 32'h4000_0000; vin[1] = 32'h4040_0000; vin[2] = 32'h4080_0000;
        vin[3] = 32'h40A0_0000; vin[4] = 32'h40C0_0000; vin[5] = 32'h40E0_0000;
        run_stream(6, 4, 5);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL bp_timeout got %0d results expected 6", got_n); end
        checks++; if (stall_seen != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d expected 5", stall_seen); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_hold got %0d violations expected 0", stall_bad); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== 32'(i + 2)) begin errors++; $display("FAIL bp[%0d] got %08h expected %08h", i, got[i], 32'(i + 2)); end
        end
    endtask

    task automatic test_mid_reset();
        int stale;
        logic [31:0] ops [0:2];
        ops[0] = 32'h4100_0000; ops[1] = 32'h4110_0000; ops[2] = 32'h40A0_0000;
        @(posedge aclk); #1;
        m_tready = 1'b0; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = ops[i];
            @(posedge aclk); #1;
        end
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL midrst_loaded got %0b expected 1", m_tvalid); end
        s_tvalid = 1'b0; areset = 1'b1;
        @(posedge aclk); #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got %0b expected 0", m_tvalid); end
        areset = 1'b0; m_tready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (m_tvalid) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale got %0d results expected 0", stale); end
        vin[0] = 32'h4120_0000;
        run_stream(1, 1000, 0);
        checks++; if (got[0] !== 32'd10) begin errors++; $display("FAIL midrst_next got %08h expected 0000000a", got[0]); end
        checks++; if (lat != 3) begin errors++; $display("FAIL midrst_latency got %0d expected 3", lat); end
    endtask

`ifdef FLOAT_TO_INT_RNE_EN
    task automatic test_rne_ties();
        logic [31:0] ex [0:3];
        vin[0] = 32'h3F00_0000; vin[1] = 32'h3FC0_0000; vin[2] = 32'h4020_0000; vin[3] = 32'hBFC0_0000;
        ex[0] = 32'd0; ex[1] = 32'd2; ex[2] = 32'd2; ex[3] = 32'hFFFF_FFFE;
        run_stream(4, 1000, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== ex[i]) begin errors++; $display("FAIL rne[%0d] got %08h expected %08h", i, got[i], ex[i]); end
        end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        areset = 1'b1; s_tvalid = 1'b0; s_tdata = 32'd0; m_tready = 1'b1;
        test_reset();
        test_basic();
        test_specials();
        test_range();
        test_backpressure();
        test_mid_reset();
`ifdef FLOAT_TO_INT_RNE_EN
        test_rne_ties();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
